// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes on the hopper bus and the
// change-dispenser state encoding used by both the dispenser and the controller.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_LO   = 2'd1;
    localparam logic [1:0] COIN_HI   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE
    } disp_state_t;

endpackage

// File: rtl/vend_stock_counter.sv
// Coin stock counter: loads INIT on reset, saturates at all-ones on refill and
// holds when a refill and a dispense land in the same cycle.
module vend_stock_counter #(
    parameter int WIDTH = 8,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= WIDTH'(INIT);
        end else if (inc && !dec) begin
            if (count != '1)
                count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Greedy two-denomination change payout driving a coin hopper with per-coin ack.
// Define CHANGE_TIMEOUT_EN to abort a payout when the hopper stops acknowledging.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W         = 8,
    parameter int HI_VAL        = 5,
    parameter int STOCK_W       = 8,
    parameter int STOCK_INIT_LO = 50,
    parameter int STOCK_INIT_HI = 20,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [AMT_W-1:0]   req_amount,
    output logic               req_ready,
    output logic [1:0]         coin,
    input  logic               coin_ack,
    output logic               done,
    output logic               short,
    output logic [AMT_W-1:0]   short_amount,
    input  logic               refill_lo,
    input  logic               refill_hi,
    output logic [STOCK_W-1:0] stock_lo,
    output logic [STOCK_W-1:0] stock_hi
);

    localparam logic [AMT_W-1:0] HI_AMT = AMT_W'(HI_VAL);
    localparam logic [AMT_W-1:0] LO_AMT = AMT_W'(1);

    if (HI_VAL < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("vend_change_dispenser: HI_VAL must exceed 1 and TIMEOUT_CYC must be positive");
    end

    disp_state_t      state;
    logic [AMT_W-1:0] remaining;
    logic             dec_lo;
    logic             dec_hi;

`ifdef CHANGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    // Stock only moves on the ack cycle of the coin actually being held.
    assign dec_lo = (state == ST_ISSUE) && coin_ack && (coin == COIN_LO);
    assign dec_hi = (state == ST_ISSUE) && coin_ack && (coin == COIN_HI);

    vend_stock_counter #(
        .WIDTH (STOCK_W),
        .INIT  (STOCK_INIT_LO)
    ) u_stock_lo (
        .clk   (clk),
        .rst   (rst),
        .inc   (refill_lo),
        .dec   (dec_lo),
        .count (stock_lo)
    );

    vend_stock_counter #(
        .WIDTH (STOCK_W),
        .INIT  (STOCK_INIT_HI)
    ) u_stock_hi (
        .clk   (clk),
        .rst   (rst),
        .inc   (refill_hi),
        .dec   (dec_hi),
        .count (stock_hi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            coin         <= COIN_NONE;
            done         <= 1'b0;
            short        <= 1'b0;
            short_amount <= '0;
            remaining    <= '0;
            req_ready    <= 1'b1;
`ifdef CHANGE_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            done         <= 1'b0;
            short        <= 1'b0;
            short_amount <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        remaining <= req_amount;
                        req_ready <= 1'b0;
                        state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
`ifdef CHANGE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (remaining >= HI_AMT && stock_hi != '0) begin
                        coin  <= COIN_HI;
                        state <= ST_ISSUE;
                    end else if (remaining != '0 && stock_lo != '0) begin
                        coin  <= COIN_LO;
                        state <= ST_ISSUE;
                    end else begin
                        // remaining is zero on a clean finish, so it doubles as the shortfall
                        done         <= 1'b1;
                        short        <= (remaining != '0);
                        short_amount <= remaining;
                        state        <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (coin_ack) begin
                        remaining <= remaining - ((coin == COIN_HI) ? HI_AMT : LO_AMT);
                        coin      <= COIN_NONE;
                        state     <= ST_SELECT;
                    end
`ifdef CHANGE_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        coin         <= COIN_NONE;
                        done         <= 1'b1;
                        short        <= 1'b1;
                        short_amount <= remaining;
                        state        <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    coin      <= COIN_NONE;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Scoreboard bench for vend_change_dispenser: directed payouts push expected coins
// and done results into queues that an independent monitor pops and compares.
module tb_vend_change_dispenser;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_amount = '0;
    logic       req_ready;
    logic [1:0] coin;
    logic       coin_ack = 1'b0;
    logic       done;
    logic       short;
    logic [7:0] short_amount;
    logic       refill_stim = 1'b0;
    logic       hopper_refill = 1'b0;
    logic       refill_hi = 1'b0;
    logic [7:0] stock_lo;
    logic [7:0] stock_hi;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       short_flag;
        logic [7:0] amount;
    } done_exp_t;

    logic [1:0] coin_q[$];
    done_exp_t  done_q[$];
    bit         hopper_en = 1'b1;
    bit         refill_on_ack = 1'b0;

    vend_change_dispenser dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .coin         (coin),
        .coin_ack     (coin_ack),
        .done         (done),
        .short        (short),
        .short_amount (short_amount),
        .refill_lo    (refill_stim | hopper_refill),
        .refill_hi    (refill_hi),
        .stock_lo     (stock_lo),
        .stock_hi     (stock_hi)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Hopper model: acknowledges each coin one cycle after it appears.
    int held = 0;
    always @(negedge clk) begin
        if (coin != COIN_NONE && hopper_en) begin
            if (held >= 1) begin
                coin_ack      = 1'b1;
                hopper_refill = refill_on_ack;
            end
            held++;
        end else begin
            coin_ack      = 1'b0;
            hopper_refill = 1'b0;
            held          = 0;
        end
    end

    logic [1:0] prev_coin = COIN_NONE;
    always @(negedge clk) begin
        done_exp_t e;
        if (coin != COIN_NONE && prev_coin == COIN_NONE) begin
            if (coin_q.size() == 0)
                check_output("unexpected_coin", coin, 0);
            else
                check_output("coin_code", coin, coin_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check_output("unexpected_done", 1, 0);
            end else begin
                e = done_q.pop_front();
                check_output("done_short", short, e.short_flag);
                check_output("done_short_amount", short_amount, e.amount);
            end
        end else if (rst) begin
            check_output("idle_short_zero", {short, short_amount}, 0);
        end
        prev_coin = coin;
    end

    task automatic push_done(input logic s, input logic [7:0] a);
        done_exp_t e;
        e.short_flag = s;
        e.amount     = a;
        done_q.push_back(e);
    endtask

    task automatic push_coins(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) coin_q.push_back(c);
    endtask

    // Returns at the negedge of the cycle right after the accept edge.
    task automatic apply_stimulus(input logic [7:0] amt);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("req_ready_before_request", req_ready, 1);
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while (!done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_output({name, "_done_seen"}, done, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        check_output("reset_coin", coin, 0);
        check_output("reset_done", done, 0);
        check_output("reset_short", short, 0);
        check_output("reset_short_amount", short_amount, 0);
        check_output("reset_req_ready", req_ready, 1);
        check_output("reset_stock_lo", stock_lo, 50);
        check_output("reset_stock_hi", stock_hi, 20);
        @(negedge clk);
        rst = 1'b1;

        // Greedy 7 = 5 + 1 + 1
        push_coins(COIN_HI, 1);
        push_coins(COIN_LO, 2);
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd7);
        check_output("first_coin_not_early", coin, 0);
        @(negedge clk);
        check_output("first_coin_latency", coin, COIN_HI);
        wait_done("amt7");
        check_output("amt7_stock_lo", stock_lo, 48);
        check_output("amt7_stock_hi", stock_hi, 19);

        // Zero amount: done two cycles after accept, no coin
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd0);
        check_output("zero_done_not_early", done, 0);
        @(negedge clk);
        check_output("zero_done_latency", done, 1);
        check_output("zero_coin_idle", coin, 0);
        @(negedge clk);
        check_output("zero_done_one_cycle", done, 0);

        // Drain the high-coin stock, then pay with unit coins only
        push_coins(COIN_HI, 19);
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd95);
        wait_done("drain_hi");
        check_output("drain_hi_stock_hi", stock_hi, 0);
        check_output("drain_hi_stock_lo", stock_lo, 48);

        push_coins(COIN_LO, 6);
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd6);
        wait_done("amt6_lo_only");
        check_output("amt6_stock_lo", stock_lo, 42);

        // Leave one unit coin, then request 3 -> shortfall of 2
        push_coins(COIN_LO, 41);
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd41);
        wait_done("drain_lo");
        check_output("drain_lo_stock_lo", stock_lo, 1);

        push_coins(COIN_LO, 1);
        push_done(1'b1, 8'd2);
        apply_stimulus(8'd3);
        wait_done("short3");
        check_output("short3_stock_lo", stock_lo, 0);

        // Refill alone, then refill coincident with a unit-coin ack
        refill_stim = 1'b1;
        @(negedge clk);
        refill_stim = 1'b0;
        @(negedge clk);
        check_output("refill_lo_single", stock_lo, 1);

        refill_on_ack = 1'b1;
        push_coins(COIN_LO, 1);
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd1);
        wait_done("refill_with_ack");
        refill_on_ack = 1'b0;
        check_output("refill_with_ack_stock_lo", stock_lo, 1);

        // High-coin refill up to and past saturation
        refill_hi = 1'b1;
        repeat (254) @(negedge clk);
        check_output("refill_hi_254", stock_hi, 254);
        @(negedge clk);
        check_output("refill_hi_255", stock_hi, 255);
        @(negedge clk);
        check_output("refill_hi_saturate", stock_hi, 255);
        refill_hi = 1'b0;

        // Reset while a high coin is held without ack
        hopper_en = 1'b0;
        push_coins(COIN_HI, 1);
        apply_stimulus(8'd7);
        begin
            int guard = 0;
            while (coin == COIN_NONE && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        check_output("abort_coin_held", coin, COIN_HI);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("abort_coin_dropped", coin, 0);
        check_output("abort_stock_lo", stock_lo, 50);
        check_output("abort_stock_hi", stock_hi, 20);
        check_output("abort_no_done", done, 0);
        check_output("abort_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        hopper_en = 1'b1;
        repeat (3) @(negedge clk);

        push_coins(COIN_HI, 1);
        push_done(1'b0, 8'd0);
        apply_stimulus(8'd5);
        wait_done("post_reset_amt5");
        check_output("post_reset_stock_hi", stock_hi, 19);

`ifdef CHANGE_TIMEOUT_EN
        hopper_en = 1'b0;
        push_coins(COIN_LO, 1);
        push_done(1'b1, 8'd3);
        apply_stimulus(8'd3);
        wait_done("timeout");
        check_output("timeout_stock_lo", stock_lo, 50);
        check_output("timeout_coin_idle", coin, 0);
        hopper_en = 1'b1;
`endif

        repeat (4) @(negedge clk);
        check_output("coins_outstanding", coin_q.size(), 0);
        check_output("dones_outstanding", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Payout side of the vending machine coin path. Accepts a change amount from the vend controller and drives a coin hopper one coin at a time on the same 2-bit coin code, using a per-coin ack handshake. Selects coins greedily from two denominations with on-chip stock counters, and reports any shortfall when stock runs out.

Parameters:
AMT_W, 8, width of change amount and remaining-amount register
HI_VAL, 5, value of the high-denomination coin in unit coins (must be >1)
STOCK_W, 8, width of each stock counter
STOCK_INIT_LO, 50, low-coin stock loaded at reset
STOCK_INIT_HI, 20, high-coin stock loaded at reset
TIMEOUT_CYC, 255, hopper ack timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req_valid  in  1  change request valid
req_amount  in  AMT_W  change to pay, in unit coins
req_ready  out  1  high only in IDLE
coin  out  2  0=none, 1=unit coin, 2=high coin, 3=never driven
coin_ack  in  1  hopper accepted current coin
done  out  1  one-cycle pulse, payout finished
short  out  1  valid with done: payout incomplete
short_amount  out  AMT_W  valid with done: unpaid remainder, else 0
refill_lo  in  1  add one unit coin to stock
refill_hi  in  1  add one high coin to stock
stock_lo  out  STOCK_W  current unit-coin stock
stock_hi  out  STOCK_W  current high-coin stock

Behaviour:
- Reset (async, rst=0): state=IDLE, coin=0, done=0, short=0, short_amount=0, remaining=0, stock_lo=STOCK_INIT_LO, stock_hi=STOCK_INIT_HI. Reset mid-payout drops the coin to 0 immediately. No done is issued for the aborted request.
- All outputs are registered.
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE: req_ready=1. On req_valid, latch remaining=req_amount and go to SELECT.
- SELECT: evaluate in this order:
  - remaining>=HI_VAL and stock_hi>0: coin<=2, go to ISSUE.
  - remaining>=1 and stock_lo>0: coin<=1, go to ISSUE.
  - remaining==0: go to DONE with short=0.
  - otherwise: go to DONE with short=1.
- ISSUE: hold coin stable until coin_ack=1. On ack:
  - decrement remaining by the coin value and the matching stock by 1;
  - coin<=0 on the next cycle, go to SELECT.
  - Coins are therefore separated by at least one idle (coin=0) cycle.
- DONE: done=1 for exactly one cycle. short and short_amount (=remaining when short) are valid that cycle and 0 otherwise. Return to IDLE.
- Latency: first coin is driven 2 cycles after the accept edge. A zero amount gives done 2 cycles after accept with no coin.
- req_valid outside IDLE is ignored. coin_ack outside ISSUE is ignored.
- Stock counters:
  - refill saturates at 2^STOCK_W-1;
  - decrement never goes below 0 (guaranteed by SELECT);
  - refill and decrement of the same counter in the same cycle leaves it unchanged;
  - a refill arriving during SELECT is seen on the next SELECT evaluation.
- remaining never underflows, because a coin is only chosen when remaining>=its value.

Optional Feature:
Macro CHANGE_TIMEOUT_EN.
- Defined: a cycle counter runs in ISSUE and clears on entry. If coin_ack is not seen within TIMEOUT_CYC cycles:
  - coin<=0;
  - stock and remaining are unchanged;
  - go to DONE with short=1 and short_amount=remaining.
- Not defined: ISSUE waits for ack indefinitely and no counter is synthesized.
- The port list is identical in both builds.

Decomposition:
- Shared package vend_pkg: coin code constants (COIN_NONE=0, COIN_LO=1, COIN_HI=2) and the dispenser state enum, shared with the vend controller.
- Sub-module vend_stock_counter: saturating up/down counter with parameterized init value and width, instantiated twice (lo and hi).

Test Plan:
1. Amount 7, stock 50/20, ack one cycle after each coin -> coin sequence 2,1,1, done with short=0; stock_lo=48, stock_hi=19.
2. Amount 0 -> done 2 cycles after accept, coin stays 0, short=0.
3. stock_hi=0, amount 6 -> six coin=1 issues, then done, short=0, stock_lo drops by 6.
4. stock_lo=1, stock_hi=0, amount 3 -> one coin=1, then done with short=1, short_amount=2, stock_lo=0.
5. refill_lo pulsed in the same cycle as ack of a unit coin -> stock_lo unchanged. refill_hi at 255 with STOCK_W=8 -> stays 255.
6. rst low while coin=2 is held in ISSUE -> coin=0 immediately, stocks back to 50/20, no done. With CHANGE_TIMEOUT_EN and no ack for 255 cycles -> done, short=1, short_amount=remaining.
